// File: rtl/key_conditioner.sv
// key_conditioner: front end for the record/play/stop push-buttons.
// The block synchronises and debounces each raw key on its own. It then emits at most one
// arbitrated single-cycle command pulse per clock, plus a per-key long-press pulse.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_key_raw    raw asynchronous keys (0 = record, 1 = play, 2 = stop)
//   o_key_pulse  one-cycle command pulse, at most one bit set (stop > record > play)
//   o_key_long   one-cycle long-press pulse per key, once per press
//   o_key_level  debounced pressed level (1 = pressed)
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_key_raw,
  output logic [2:0] o_key_pulse,
  output logic [2:0] o_key_long,
  output logic [2:0] o_key_level
);

  localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LcntW = $clog2(LONG_CYCLES + 1);
  // dcnt value from which the next increment would reach DEBOUNCE_CYCLES
  localparam logic [DcntW-1:0] DebLast  = DcntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LcntW-1:0] LongMax  = LcntW'(LONG_CYCLES);
  localparam logic [LcntW-1:0] LongLast = LcntW'(LONG_CYCLES - 1);

  logic [2:0]            key_p;
  logic [2:0]            s1_q, s2_q;
  logic [2:0]            deb_q, deb_d;
  logic [2:0][DcntW-1:0] dcnt_q, dcnt_d;
  logic [2:0][LcntW-1:0] lcnt_q, lcnt_d;
  logic [2:0]            pend_q, pend_d;
  logic [2:0]            armed_q, armed_d;
  logic [2:0]            pulse_q, long_q, long_d;
  logic [2:0]            press, grant;
  logic [1:0]            fill_q, fill_d;
  logic                  sync_valid;

  always_comb begin
    key_p = ACTIVE_LOW ? ~i_key_raw : i_key_raw;
  end

  // s2 is cleared by reset, so its zero means nothing until it has been reloaded from a
  // post-reset sample. Without this a key held through reset would arm immediately.
  always_comb begin
    sync_valid = (fill_q == 2'd2);
    fill_d     = sync_valid ? fill_q : fill_q + 2'd1;
  end

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    lcnt_d = lcnt_q;
    long_d = '0;
    press  = '0;
    for (int k = 0; k < 3; k++) begin
      // Debounce: any sample equal to the accepted level restarts the window.
      if (s2_q[k] == deb_q[k]) begin
        dcnt_d[k] = '0;
      end else if (dcnt_q[k] == DebLast) begin
        deb_d[k]  = s2_q[k];
        dcnt_d[k] = '0;
      end else begin
        dcnt_d[k] = dcnt_q[k] + DcntW'(1);
      end

      press[k] = ~deb_q[k] & deb_d[k] & armed_q[k];

      // Long press: saturating count, pulse only on the step that reaches LONG_CYCLES.
      if (!deb_q[k]) begin
        lcnt_d[k] = '0;
      end else if (armed_q[k] && (lcnt_q[k] != LongMax)) begin
        lcnt_d[k] = lcnt_q[k] + LcntW'(1);
        long_d[k] = (lcnt_q[k] == LongLast);
      end
    end
  end

  always_comb begin
    armed_d = armed_q | ({3{sync_valid}} & ~deb_q & ~s2_q);
  end

  // Fixed priority: stop (2) > record (0) > play (1).
  always_comb begin
    grant = 3'b000;
    if (pend_q[2]) begin
      grant = 3'b100;
    end else if (pend_q[0]) begin
      grant = 3'b001;
    end else if (pend_q[1]) begin
      grant = 3'b010;
    end
  end

  // A new press for the key being emitted this cycle re-sets its pending bit.
  always_comb begin
    pend_d = (pend_q & ~grant) | press;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      lcnt_q  <= '0;
      pend_q  <= '0;
      armed_q <= '0;
      pulse_q <= '0;
      long_q  <= '0;
      fill_q  <= '0;
    end else begin
      s1_q    <= key_p;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      lcnt_q  <= lcnt_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
      pulse_q <= grant;
      long_q  <= long_d;
      fill_q  <= fill_d;
    end
  end

  assign o_key_pulse = pulse_q;
  assign o_key_long  = long_q;
  assign o_key_level = deb_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, active-low keys).
// Expected pulse/long events are queued with their cycle number when stimulus is driven.
// They are popped and compared every cycle; a cycle without a queued event expects zero.
module tb_key_conditioner;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_raw;
  logic [2:0] key_pulse, key_long, key_level;

  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  t0;
  ev_t pulse_exp_q[$];
  ev_t long_exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_key_raw  (key_raw),
    .o_key_pulse(key_pulse),
    .o_key_long (key_long),
    .o_key_level(key_level)
  );

  task automatic push_pulse(input int c, input logic [2:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    pulse_exp_q.push_back(e);
  endtask

  task automatic push_long(input int c, input logic [2:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    long_exp_q.push_back(e);
  endtask

  // Advance one edge, then check both pulse outputs against the scoreboard.
  task automatic cycle();
    logic [2:0] exp_p, exp_l;
    @(posedge clk);
    #1;
    exp_p = 3'b000;
    exp_l = 3'b000;
    if (pulse_exp_q.size() > 0 && pulse_exp_q[0].cyc == cyc) begin
      exp_p = pulse_exp_q[0].val;
      void'(pulse_exp_q.pop_front());
    end
    if (long_exp_q.size() > 0 && long_exp_q[0].cyc == cyc) begin
      exp_l = long_exp_q[0].val;
      void'(long_exp_q.pop_front());
    end
    n_vec++;
    assert (key_pulse === exp_p) else begin
      n_err++;
      $error("FAIL pulse cyc=%0d got=%b exp=%b", cyc, key_pulse, exp_p);
    end
    n_vec++;
    assert (key_long === exp_l) else begin
      n_err++;
      $error("FAIL long cyc=%0d got=%b exp=%b", cyc, key_long, exp_l);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_level(input string tag, input logic [2:0] exp);
    n_vec++;
    assert (key_level === exp) else begin
      n_err++;
      $error("FAIL level %s cyc=%0d got=%b exp=%b", tag, cyc, key_level, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    key_raw = 3'b111;
    run(2);
    check_level("reset", 3'b000);
    rst = 1'b0;
    run(6);

    // 1: single press of play, long press, no repeat while held.
    t0 = cyc;
    key_raw = 3'b101;
    push_pulse(t0 + 7, 3'b010);
    push_long(t0 + 16, 3'b010);
    run(5);
    check_level("t1_before", 3'b000);
    cycle();
    check_level("t1_after", 3'b010);
    run(20);
    key_raw = 3'b111;
    run(10);
    check_level("t1_release", 3'b000);

    // 2: bounces shorter than the window are rejected, then a clean press.
    key_raw = 3'b110;
    run(3);
    key_raw = 3'b111;
    cycle();
    key_raw = 3'b110;
    run(3);
    key_raw = 3'b111;
    run(8);
    check_level("t2_bounce", 3'b000);
    t0 = cyc;
    key_raw = 3'b110;
    push_pulse(t0 + 7, 3'b001);
    run(6);
    check_level("t2_clean", 3'b001);
    key_raw = 3'b111;
    run(12);
    check_level("t2_release", 3'b000);

    // 3: all keys together, emitted stop, record, play on consecutive cycles.
    t0 = cyc;
    key_raw = 3'b000;
    push_pulse(t0 + 7, 3'b100);
    push_pulse(t0 + 8, 3'b001);
    push_pulse(t0 + 9, 3'b010);
    push_long(t0 + 16, 3'b111);
    run(20);
    check_level("t3_held", 3'b111);
    key_raw = 3'b111;
    run(10);

    // 4: stop held through reset stays silent until released and pressed again.
    key_raw = 3'b011;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(20);
    check_level("t4_held", 3'b100);
    key_raw = 3'b111;
    run(6);
    check_level("t4_released", 3'b000);
    t0 = cyc;
    key_raw = 3'b011;
    push_pulse(t0 + 7, 3'b100);
    push_long(t0 + 16, 3'b100);
    run(20);
    key_raw = 3'b111;
    run(10);

    // 5: reset just before record would be accepted discards everything.
    key_raw = 3'b110;
    run(5);
    rst = 1'b1;
    cycle();
    check_level("t5_reset", 3'b000);
    rst = 1'b0;
    run(20);
    check_level("t5_held", 3'b001);
    key_raw = 3'b111;
    run(10);

    // 6: play then stop one cycle later, emitted in acceptance order.
    t0 = cyc;
    key_raw = 3'b101;
    cycle();
    key_raw = 3'b001;
    push_pulse(t0 + 7, 3'b010);
    push_pulse(t0 + 8, 3'b100);
    push_long(t0 + 16, 3'b010);
    push_long(t0 + 17, 3'b100);
    run(20);
    key_raw = 3'b111;
    run(10);

    n_vec++;
    assert (pulse_exp_q.size() === 0) else begin
      n_err++;
      $error("FAIL pulse_queue left=%0d exp=0", pulse_exp_q.size());
    end
    n_vec++;
    assert (long_exp_q.size() === 0) else begin
      n_err++;
      $error("FAIL long_queue left=%0d exp=0", long_exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end conditioner for the three push-buttons that drive the record/play/stop controller. It synchronises the raw, bouncing, asynchronous key inputs and debounces each one independently. It then delivers at most one single-cycle command pulse per clock to the top-level FSM, plus a separate long-press indication. It sits directly upstream of the top controller's `i_key_0/1/2` inputs, in the same `i_clk` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Must be ≥ 2.
- `LONG_CYCLES`, default 50_000_000: cycles a debounced press must persist to fire a long-press pulse (1 s). Must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means raw key reads 0 when pressed (board convention).

Ports:
- `i_clk`  in  1: system clock. One clock; reset is synchronous and active-high.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_key_raw`  in  3: raw asynchronous buttons. Index 0 = record, 1 = play, 2 = stop.
- `o_key_pulse`  out  3: one-cycle command pulses. At most one bit high per cycle.
- `o_key_long`  out  3: one-cycle long-press pulses, one per key.
- `o_key_level`  out  3: debounced pressed level (1 = pressed).

## Operation
- **Input normalisation:** `p = ACTIVE_LOW ? ~i_key_raw : i_key_raw`. Each bit passes through a 2-FF synchroniser (`s1`, `s2`). All downstream logic uses `s2` only.
- **Per-key debounce:** the counter `dcnt[k]` (width `$clog2(DEBOUNCE_CYCLES+1)`) works as follows:
  - If `s2[k] == deb[k]`: `dcnt` ← 0.
  - Otherwise `dcnt` increments.
  - When the increment would reach `DEBOUNCE_CYCLES`: `deb[k]` ← `s2[k]` and `dcnt` ← 0.
  - `o_key_level = deb`.
- **Press event:** `deb[k]` 0→1 while `armed[k]` = 1.
  - `armed[k]` clears on reset.
  - `armed[k]` sets at the first cycle `deb[k]` = 0 and `s2[k]` = 0 after reset.
  - Effect: a key held through reset release never produces a press or long pulse until it has been released once.
- **Pending/arbitration:** a press event sets `pend[k]`. Each cycle, the highest-priority pending bit is emitted on `o_key_pulse` and cleared.
  - Priority: key 2 (stop) > key 0 (record) > key 1 (play).
  - Lower-priority pending bits stay set and emit on later cycles, one per cycle.
  - A new event for a key already pending merges; no second pulse.
  - A new event arriving in the same cycle that key is emitted re-sets `pend[k]`; set wins over clear.
- **Long press:** counter `lcnt[k]`.
  - Clears when `deb[k]` = 0.
  - Increments while `deb[k]` = 1 and `armed[k]`, saturating at `LONG_CYCLES`.
  - The transition to `LONG_CYCLES` pulses `o_key_long[k]` for one cycle: exactly once per press, no auto-repeat.
  - Not arbitrated; may coincide with any `o_key_pulse`.
- **Release:** `deb[k]` 1→0 produces no pulse.
- **Reset:** `s1`, `s2`, `deb`, `dcnt`, `lcnt`, `pend`, `armed` ← 0. All outputs registered and 0 in the cycle after the reset edge.

## Timing
- All outputs are registered; no combinational path from `i_key_raw`.
- Let E0 be the first rising edge that samples a new raw level into `s1`:
  - `s2` updates at E0+1.
  - `deb` flips at E0+1+`DEBOUNCE_CYCLES` if the raw level holds stable throughout.
  - `pend` sets at that same edge.
  - `o_key_pulse` asserts at E0+2+`DEBOUNCE_CYCLES` when nothing of higher priority is pending.
- A bounce (raw returns to the `deb` level) at any cycle resets `dcnt`. The `DEBOUNCE_CYCLES` window restarts from the next differing sample.
- `o_key_long[k]` asserts at the edge where `lcnt` reaches `LONG_CYCLES`, i.e. `LONG_CYCLES` edges after the `deb` 0→1 edge.
- Reset asserted mid-press or mid-count:
  - Aborts all state next edge.
  - Pending pulses are discarded.
  - A held key must be released (debounced) then pressed again to generate a pulse.
- Worst-case pulse delay under arbitration: 2 extra cycles (all three keys accepted in the same cycle).

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_LOW`=1.
1. Key 1 raw 1→0 at E0, held low → `o_key_level[1]`=1 from E0+5; `o_key_pulse`=3'b010 for exactly one cycle at E0+6; `o_key_long[1]` pulses at E0+15; no further pulses while held.
2. Key 0 raw low for 3 cycles, high 1, low 3, high → no `o_key_level`, no pulses. Then a clean low for 6 cycles → one pulse 3'b001.
3. All three keys pressed at the same edge → `o_key_pulse` = 3'b100, then 3'b001, then 3'b010 on three consecutive cycles, starting at E0+6.
4. Key 2 held low, `i_rst` pulsed 1 cycle, key still held for 20 cycles → no `o_key_pulse` and no `o_key_long`. Release for 6 cycles, press again → one 3'b100 pulse.
5. `i_rst` asserted during cycle E0+4 of a key 0 press → all outputs 0 after the reset edge; no pulse emitted afterward while held.
6. Key 1 press followed by a key 2 press 1 cycle later → pulses 3'b010 at E0+6, 3'b100 at E0+7, each exactly one cycle.
